// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard : 2R/1W register file with per-register busy scoreboard
// Rev 1.0
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              RDY1,
  output logic              RDY2,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              RSV_EN,
  input  logic [ADDR_W-1:0] RSV_A,
  input  logic              CLR,
  output logic [ADDR_W:0]   BUSY_CNT
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   r_busy_cnt;
  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic              w_inc;
  logic              w_dec;
  logic              w_zero1;
  logic              w_zero2;
  logic              w_fwd1;
  logic              w_fwd2;

  assign w_wr_ok  = WE3 && !(ZERO_REG && (A3 == '0));
  assign w_rsv_ok = RSV_EN && !(ZERO_REG && (RSV_A == '0));

  // Same-address reserve+writeback keeps the bit set, so it never decrements.
  assign w_inc = w_rsv_ok && !r_busy[RSV_A];
  assign w_dec = WE3 && r_busy[A3] && !(w_rsv_ok && (RSV_A == A3));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_busy_nxt[i] = r_busy[i];
      if (CLR)
        w_busy_nxt[i] = 1'b0;
      else if (w_rsv_ok && (RSV_A == i[ADDR_W-1:0]))
        w_busy_nxt[i] = 1'b1;
      else if (WE3 && (A3 == i[ADDR_W-1:0]))
        w_busy_nxt[i] = 1'b0;
    end
    if (ZERO_REG)
      w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[A3] <= WD3;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (CLR)
        r_busy_cnt <= '0;
      else if (w_inc && !w_dec)
        r_busy_cnt <= r_busy_cnt + 1'b1;
      else if (w_dec && !w_inc)
        r_busy_cnt <= r_busy_cnt - 1'b1;
    end
  end

  assign w_zero1 = ZERO_REG && (A1 == '0);
  assign w_zero2 = ZERO_REG && (A2 == '0);
  assign w_fwd1  = BYPASS && WE3 && (A3 == A1);
  assign w_fwd2  = BYPASS && WE3 && (A3 == A2);

  assign RD1 = w_zero1 ? '0 : (w_fwd1 ? WD3 : r_mem[A1]);
  assign RD2 = w_zero2 ? '0 : (w_fwd2 ? WD3 : r_mem[A2]);

  assign RDY1 = w_zero1 || !r_busy[A1] || w_fwd1;
  assign RDY2 = w_zero2 || !r_busy[A2] || w_fwd2;

  assign BUSY_CNT = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_regfile_scoreboard : directed bench for bypass and non-bypass builds
// Rev 1.0
// ============================================================================
module tb_regfile_scoreboard;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  A1, A2, A3, RSV_A;
  logic [31:0] WD3;
  logic        WE3, RSV_EN, CLR;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        rdy1_b, rdy2_b, rdy1_n, rdy2_n;
  logic [5:0]  cnt_b, cnt_n;

  int tests  = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b),
    .RDY1(rdy1_b), .RDY2(rdy2_b), .WE3(WE3), .A3(A3), .WD3(WD3),
    .RSV_EN(RSV_EN), .RSV_A(RSV_A), .CLR(CLR), .BUSY_CNT(cnt_b)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
    .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n),
    .RDY1(rdy1_n), .RDY2(rdy2_n), .WE3(WE3), .A3(A3), .WD3(WD3),
    .RSV_EN(RSV_EN), .RSV_A(RSV_A), .CLR(CLR), .BUSY_CNT(cnt_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply idle controls, settle.
  task automatic step_idle();
    @(negedge CLK);
    WE3 = 1'b0; RSV_EN = 1'b0; CLR = 1'b0;
  endtask

  initial begin
    RST = 1'b0; A1 = 5'd7; A2 = 5'd31; A3 = '0; RSV_A = '0; WD3 = '0;
    WE3 = 1'b0; RSV_EN = 1'b0; CLR = 1'b0;
    #3;
    chk("rst_rd1", rd1_b, 32'h0);
    chk("rst_rd2", rd2_b, 32'h0);
    chk("rst_rdy1", {31'b0, rdy1_b}, 32'h1);
    chk("rst_rdy2", {31'b0, rdy2_b}, 32'h1);
    chk("rst_cnt", {26'b0, cnt_b}, 32'h0);
    @(negedge CLK); RST = 1'b1;

    // Register 0: writes dropped, never reserved
    @(negedge CLK); WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hDEADBEEF; A1 = 5'd0;
    #2 chk("zero_wr_fwd", rd1_b, 32'h0);
    @(negedge CLK); WE3 = 1'b0; RSV_EN = 1'b1; RSV_A = 5'd0;
    #2 chk("zero_rd", rd1_b, 32'h0);
    step_idle();
    #2 chk("zero_cnt", {26'b0, cnt_b}, 32'h0);
    chk("zero_rdy", {31'b0, rdy1_b}, 32'h1);

    // Reserve 5 and 9, then bypassed writeback to 5
    @(negedge CLK); RSV_EN = 1'b1; RSV_A = 5'd5;
    @(negedge CLK); RSV_A = 5'd9;
    step_idle(); A1 = 5'd5;
    #2 chk("rsv2_cnt", {26'b0, cnt_b}, 32'd2);
    chk("rsv5_rdy", {31'b0, rdy1_b}, 32'h0);
    @(negedge CLK); WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h1234;
    #2 chk("byp_rd1", rd1_b, 32'h1234);
    chk("byp_rdy1", {31'b0, rdy1_b}, 32'h1);
    step_idle();
    #2 chk("wb5_cnt", {26'b0, cnt_b}, 32'd1);
    chk("wb5_rd1", rd1_b, 32'h1234);

    // Reserve and writeback to 9 on the same edge
    @(negedge CLK); RSV_EN = 1'b1; RSV_A = 5'd9; WE3 = 1'b1; A3 = 5'd9; WD3 = 32'hAA; A1 = 5'd9;
    step_idle();
    #2 chk("same9_rd", rd1_b, 32'hAA);
    chk("same9_busy", {31'b0, rdy1_b}, 32'h0);
    chk("same9_cnt", {26'b0, cnt_b}, 32'd1);

    // Reserve 3 while writing back 9
    @(negedge CLK); RSV_EN = 1'b1; RSV_A = 5'd3; WE3 = 1'b1; A3 = 5'd9; WD3 = 32'hBB;
    step_idle(); A1 = 5'd3; A2 = 5'd9;
    #2 chk("rsv3_rdy", {31'b0, rdy1_b}, 32'h0);
    chk("wb9_rdy", {31'b0, rdy2_b}, 32'h1);
    chk("wb9_rd2", rd2_b, 32'hBB);
    chk("x39_cnt", {26'b0, cnt_b}, 32'd1);

    // Flush overrides reservation; the data write still lands
    @(negedge CLK); CLR = 1'b1; RSV_EN = 1'b1; RSV_A = 5'd4; WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h44;
    step_idle(); A1 = 5'd4; A2 = 5'd3;
    #2 chk("clr_cnt", {26'b0, cnt_b}, 32'd0);
    chk("clr_rdy4", {31'b0, rdy1_b}, 32'h1);
    chk("clr_rd4", rd1_b, 32'h44);
    chk("clr_rdy3", {31'b0, rdy2_b}, 32'h1);

    // Asynchronous reset with three registers busy
    @(negedge CLK); RSV_EN = 1'b1; RSV_A = 5'd1;
    @(negedge CLK); RSV_A = 5'd2;
    @(negedge CLK); RSV_A = 5'd6;
    step_idle(); A1 = 5'd1; A2 = 5'd5;
    #2 chk("pre_rst_cnt", {26'b0, cnt_b}, 32'd3);
    RST = 1'b0;
    #1 chk("arst_cnt", {26'b0, cnt_b}, 32'd0);
    chk("arst_rdy1", {31'b0, rdy1_b}, 32'h1);
    chk("arst_rd2", rd2_b, 32'h0);
    @(negedge CLK); RST = 1'b1;

    // Non-bypass build: written register stays not-ready until the next edge
    @(negedge CLK); WE3 = 1'b1; A3 = 5'd12; WD3 = 32'h77;
    @(negedge CLK); WE3 = 1'b0; RSV_EN = 1'b1; RSV_A = 5'd12;
    @(negedge CLK); RSV_EN = 1'b0; WE3 = 1'b1; A3 = 5'd12; WD3 = 32'h55; A1 = 5'd12;
    #2 chk("nb_rd_old", rd1_n, 32'h77);
    chk("nb_rdy_lo", {31'b0, rdy1_n}, 32'h0);
    chk("b_rd_fwd", rd1_b, 32'h55);
    step_idle();
    #2 chk("nb_rd_new", rd1_n, 32'h55);
    chk("nb_rdy_hi", {31'b0, rdy1_n}, 32'h1);
    chk("nb_cnt", {26'b0, cnt_n}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
